// File: rtl/grant_monitor_pkg.sv
// rtl/grant_monitor_pkg.sv - shared arbitration types: window FSM states and source-index width
package grant_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SNAP  = 2'd2
    } state_t;

    // A single requester still needs a 1-bit source index.
    function automatic int src_width(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

endpackage

// File: rtl/grant_monitor_sat_counter.sv
// rtl/grant_monitor_sat_counter.sv - per-requester saturating service counter
module sat_counter #(
    parameter int CWID = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [CWID-1:0] count
);

    logic [CWID-1:0] r_count;

    // clr restarts the count, seeding it with the grant of the clearing cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= CWID'(inc);
        end else if (inc && (r_count != {CWID{1'b1}})) begin
            r_count <= r_count + CWID'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/grant_monitor.sv
// rtl/grant_monitor.sv - grant output stage, multi-hot error flag and windowed per-requester service counts
module grant_monitor
    import grant_monitor_pkg::*;
#(
    parameter  int NUM_REQS = 4,
    parameter  int WIDTH    = 8,
    parameter  int CWID     = 8,
    parameter  int WINDOW   = 16,
    localparam int SRCW     = src_width(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQS-1:0]      gnt,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     en,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [SRCW-1:0]          out_src,
    output logic                     err,
    output logic                     snap_valid,
    output logic [NUM_REQS*CWID-1:0] flat_counts
);

    localparam int WCW = $clog2(WINDOW + 1);

    logic                     w_any;
    logic                     w_multi;
    logic [NUM_REQS-1:0]      w_low;
    logic [SRCW-1:0]          w_src;
    logic                     w_counting;
    logic                     w_clr;
    logic [NUM_REQS-1:0]      w_inc;
    logic [CWID-1:0]          w_count [NUM_REQS];
    logic [NUM_REQS*CWID-1:0] w_next_flat;

    logic                     r_out_valid;
    logic [WIDTH-1:0]         r_out_data;
    logic [SRCW-1:0]          r_out_src;
    logic                     r_err;
    logic                     r_snap_valid;
    logic [NUM_REQS*CWID-1:0] r_flat;
    logic [WCW-1:0]           r_wcnt;
    state_t                   r_state;

    assign w_any   = |gnt;
    assign w_multi = |(gnt & (gnt - NUM_REQS'(1)));
    assign w_low   = gnt & (~gnt + NUM_REQS'(1));

    always_comb begin
        w_src = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (gnt[i]) begin
                w_src = SRCW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= data_in;
            end
            if (w_any && !w_multi) begin
                r_out_src <= w_src;
            end
            if (w_multi) begin
                r_err <= 1'b1;
            end
        end
    end

    // The SNAP-cycle grant seeds the next window rather than the one being captured.
    assign w_counting = (r_state == ST_COUNT) || (r_state == ST_SNAP);
    assign w_clr      = (r_state == ST_SNAP);

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_cnt
        assign w_inc[i] = w_low[i] && w_counting;

        sat_counter #(.CWID(CWID)) u_sat_counter (
            .clk   (clk),
            .rst   (rst),
            .clr   (w_clr),
            .inc   (w_inc[i]),
            .count (w_count[i])
        );

        assign w_next_flat[i*CWID +: CWID] =
            (w_inc[i] && (w_count[i] != {CWID{1'b1}})) ? w_count[i] + CWID'(1) : w_count[i];
    end

    // Snapshot is taken from the counters' next values so snap_valid and data line up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wcnt       <= '0;
            r_snap_valid <= 1'b0;
            r_flat       <= '0;
        end else begin
            r_snap_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    r_wcnt <= r_wcnt + WCW'(1);
                    if (r_wcnt == WCW'(WINDOW - 1)) begin
                        r_state      <= ST_SNAP;
                        r_snap_valid <= 1'b1;
                        r_flat       <= w_next_flat;
                    end else if (!en) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SNAP: begin
                    r_wcnt  <= '0;
                    r_state <= en ? ST_COUNT : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_src     = r_out_src;
    assign err         = r_err;
    assign snap_valid  = r_snap_valid;
    assign flat_counts = r_flat;

endmodule

// File: tb/tb_grant_monitor.sv
// tb/tb_grant_monitor.sv - directed bench with a window-level reference model for grant_monitor
module tb_grant_monitor;

    localparam int WIN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        en2 = 1'b0;
    logic [3:0]  gnt = '0;
    logic [7:0]  data_in = '0;

    logic        out_valid, err, snap_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic [31:0] flat_counts;

    logic        out_valid2, err2, snap_valid2;
    logic [7:0]  out_data2;
    logic [1:0]  out_src2;
    logic [31:0] flat_counts2;

    int checks = 0;
    int errors = 0;

    // Reference model: window progress measured as counted cycles out of WIN.
    int          m_mode = 0;
    int          m_done = 0;
    int          m_cnt [4] = '{0, 0, 0, 0};
    logic [31:0] m_flat = '0;
    logic        m_snap = 1'b0;
    logic        m_valid = 1'b0;
    logic [7:0]  m_data = '0;
    logic [1:0]  m_src = '0;
    logic        m_err = 1'b0;

    grant_monitor #(.NUM_REQS(4), .WIDTH(8), .CWID(8), .WINDOW(WIN)) dut (
        .clk(clk), .rst(rst), .gnt(gnt), .data_in(data_in), .en(en),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .err(err),
        .snap_valid(snap_valid), .flat_counts(flat_counts)
    );

    grant_monitor #(.NUM_REQS(4), .WIDTH(8), .CWID(8), .WINDOW(300)) dut_sat (
        .clk(clk), .rst(rst), .gnt(gnt), .data_in(data_in), .en(en2),
        .out_valid(out_valid2), .out_data(out_data2), .out_src(out_src2), .err(err2),
        .snap_valid(snap_valid2), .flat_counts(flat_counts2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_done = 0; m_flat = '0; m_snap = 1'b0;
        m_valid = 1'b0; m_data = '0; m_src = '0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] g, input logic [7:0] d, input logic e);
        int ones;
        int low;
        ones = $countones(g);
        low  = -1;
        for (int i = 3; i >= 0; i--) if (g[i]) low = i;
        m_valid = (ones > 0);
        if (ones > 0) m_data = d;
        if (ones == 1) m_src = 2'(low);
        if (ones > 1) m_err = 1'b1;
        m_snap = 1'b0;
        if (m_mode == 1) begin
            if (low >= 0 && m_cnt[low] < 255) m_cnt[low] = m_cnt[low] + 1;
            m_done = m_done + 1;
            if (m_done == WIN) begin
                for (int i = 0; i < 4; i++) m_flat[i*8 +: 8] = 8'(m_cnt[i]);
                m_snap = 1'b1;
                m_mode = 2;
            end else if (!e) begin
                m_mode = 0;
            end
        end else if (m_mode == 2) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = (i == low) ? 1 : 0;
            m_done = 0;
            m_mode = e ? 1 : 0;
        end else if (e) begin
            m_mode = 1;
        end
    endtask

    always @(negedge clk) begin
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_src", 64'(out_src), 64'(m_src));
        chk("err", 64'(err), 64'(m_err));
        chk("snap_valid", 64'(snap_valid), 64'(m_snap));
        chk("flat_counts", 64'(flat_counts), 64'(m_flat));
    end

    task automatic tick(input logic [3:0] g, input logic [7:0] d, input logic e);
        gnt = g; data_in = d; en = e;
        @(posedge clk);
        model_step(g, d, e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1; en = 1'b0; en2 = 1'b0; gnt = '0; data_in = '0;
        #1;
        model_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_snap_valid", 64'(snap_valid), 64'd0);
        chk("rst_flat", 64'(flat_counts), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int first;
        int nsnap;
        logic [31:0] snap_flat;
        logic [3:0] pat [8];
        pat = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0011, 4'b1000, 4'b0000};

        // Output stage latency and hold
        do_reset();
        tick(4'b0100, 8'hA5, 1'b1);
        chk("lit_valid", 64'(out_valid), 64'd1);
        chk("lit_data", 64'(out_data), 64'hA5);
        chk("lit_src", 64'(out_src), 64'd2);
        tick(4'b0000, 8'h00, 1'b1);
        chk("lit_valid_idle", 64'(out_valid), 64'd0);
        chk("lit_data_hold", 64'(out_data), 64'hA5);

        // Full window of grants to requester 0
        do_reset();
        tick(4'b0000, 8'h00, 1'b1);
        first = 0; nsnap = 0; snap_flat = '0;
        for (int k = 1; k <= 16; k++) begin
            tick(4'b0001, 8'(k), 1'b1);
            if (snap_valid) begin
                nsnap++;
                if (first == 0) begin first = k; snap_flat = flat_counts; end
            end
        end
        chk("win_snap_at", 64'(first), 64'd16);
        chk("win_snap_cnt", 64'(nsnap), 64'd1);
        chk("win_flat", 64'(snap_flat), 64'h0000_0010);
        tick(4'b0000, 8'h00, 1'b0);
        chk("win_flat_hold", 64'(flat_counts), 64'h0000_0010);

        // Multi-hot grant: sticky err, lowest bit counted
        do_reset();
        tick(4'b0000, 8'h00, 1'b1);
        tick(4'b0110, 8'h3C, 1'b1);
        chk("mh_err", 64'(err), 64'd1);
        chk("mh_valid", 64'(out_valid), 64'd1);
        chk("mh_data", 64'(out_data), 64'h3C);
        chk("mh_src_hold", 64'(out_src), 64'd0);
        for (int k = 0; k < 15; k++) tick(4'b0000, 8'h00, 1'b1);
        chk("mh_snap", 64'(snap_valid), 64'd1);
        chk("mh_flat", 64'(flat_counts), 64'h0000_0100);
        chk("mh_err_sticky", 64'(err), 64'd1);

        // Pause en for 3 cycles at wcnt=5
        do_reset();
        tick(4'b0000, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) tick(4'b1000, 8'h10, 1'b1);
        tick(4'b0010, 8'h20, 1'b0);
        tick(4'b0010, 8'h21, 1'b0);
        tick(4'b0010, 8'h22, 1'b0);
        tick(4'b0010, 8'h23, 1'b1);
        first = 0; snap_flat = '0;
        for (int k = 1; k <= 12; k++) begin
            tick(4'b1000, 8'h30, 1'b1);
            if (snap_valid && first == 0) begin first = k + 9; snap_flat = flat_counts; end
        end
        chk("pause_snap_at", 64'(first), 64'd19);
        chk("pause_flat", 64'(snap_flat), 64'h0F00_0100);

        // Reset mid-window discards it
        do_reset();
        tick(4'b0000, 8'h00, 1'b1);
        for (int k = 0; k < 10; k++) tick(4'b0001, 8'h44, 1'b1);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        do_reset();
        nsnap = 0;
        for (int k = 0; k < 14; k++) begin
            tick(4'b0000, 8'h00, 1'b1);
            if (snap_valid) nsnap++;
        end
        chk("rst_no_snap", 64'(nsnap), 64'd0);

        // Mixed pattern across several windows, en dropped briefly
        do_reset();
        for (int k = 0; k < 60; k++) begin
            tick(pat[k % 8], 8'(k * 7), (k >= 20 && k <= 22) ? 1'b0 : 1'b1);
        end

        // Saturation with a 300-cycle window
        do_reset();
        en2 = 1'b1;
        tick(4'b0000, 8'h00, 1'b0);
        first = 0; nsnap = 0; snap_flat = '0;
        for (int k = 1; k <= 300; k++) begin
            tick(4'b0001, 8'h11, 1'b0);
            if (snap_valid2) begin
                nsnap++;
                if (first == 0) begin first = k; snap_flat = flat_counts2; end
            end
        end
        chk("sat_snap_at", 64'(first), 64'd300);
        chk("sat_snap_cnt", 64'(nsnap), 64'd1);
        chk("sat_flat", 64'(snap_flat), 64'h0000_00FF);
        chk("sat_valid", 64'(out_valid2), 64'd1);
        chk("sat_data", 64'(out_data2), 64'h11);
        chk("sat_src", 64'(out_src2), 64'd0);
        chk("sat_err", 64'(err2), 64'd0);
        en2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
